// File: rtl/fib_num_gen.sv
// rtl/fib_num_gen.sv - iterative Fibonacci term generator with done/error/overflow status
// Optional build macro: FIB_SATURATE_EN (saturate data_out to all ones on overflow)
module fib_num_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int FIB_ORDER  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [FIB_ORDER-1:0]  order,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  done,
    output logic                  error,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        CALC = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [FIB_ORDER-1:0]  cnt;
    logic [FIB_ORDER-1:0]  order_q;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] ovf_value;

    // One extra bit on the adder exposes the carry used for overflow detection
    assign sum = {1'b0, a} + {1'b0, b};

`ifdef FIB_SATURATE_EN
    assign ovf_value = {DATA_WIDTH{1'b1}};
`else
    assign ovf_value = sum[DATA_WIDTH-1:0];
`endif

    // Control FSM with registered status outputs; b always holds F(cnt)
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            cnt      <= '0;
            order_q  <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // clear blocks a pending request until it drops
                    if (!clear && load) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    order_q <= order;
                    if (order == '0) begin
                        error    <= 1'b1;
                        data_out <= '0;
                        state    <= ERR;
                    end else begin
                        a     <= data_in;
                        b     <= data_in;
                        cnt   <= {{(FIB_ORDER-1){1'b0}}, 1'b1};
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (clear) begin
                        state <= IDLE;
                    end else if (cnt == order_q) begin
                        data_out <= b;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (sum[DATA_WIDTH]) begin
                        overflow <= 1'b1;
                        data_out <= ovf_value;
                        state    <= ERR;
                    end else begin
                        a   <= b;
                        b   <= sum[DATA_WIDTH-1:0];
                        cnt <= cnt + {{(FIB_ORDER-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (!load) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    // load is ignored here; only clear leaves the error state
                    if (clear) begin
                        error    <= 1'b0;
                        overflow <= 1'b0;
                        data_out <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_num_gen.sv
// tb/tb_fib_num_gen.sv - directed self-checking bench for fib_num_gen
module tb_fib_num_gen;

    logic        clk;
    logic        reset;
    logic        load;
    logic        clear;
    logic [15:0] order;
    logic [63:0] data_in;
    logic        done;
    logic        error;
    logic        overflow;
    logic [63:0] data_out;

    int n_checks;
    int n_errors;
    int lat;

    fib_num_gen dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .clear    (clear),
        .order    (order),
        .data_in  (data_in),
        .done     (done),
        .error    (error),
        .overflow (overflow),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic d, input logic e, input logic o);
        check({tag, "_done"}, {63'd0, done}, {63'd0, d});
        check({tag, "_error"}, {63'd0, error}, {63'd0, e});
        check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, o});
    endtask

    // Raise load with operands, return edges after capture edge E1 until a flag is seen
    task automatic run_req(input logic [63:0] seed, input logic [15:0] ord, output int l);
        @(negedge clk);
        load = 1'b1;
        data_in = seed;
        order = ord;
        @(posedge clk);
        @(posedge clk);
        #1;
        l = 0;
        while (!(done || error || overflow) && l < 1000) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic drop_load();
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check_flags("clear_exit", 1'b0, 1'b0, 1'b0);
        check("clear_exit_data", data_out, 64'd0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        load = 1'b0;
        clear = 1'b0;
        order = '0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check("reset_data", data_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic results with exact latency
        run_req(64'd1, 16'd10, lat);
        check("s1o10_lat", 64'(lat), 64'd10);
        check_flags("s1o10", 1'b1, 1'b0, 1'b0);
        check("s1o10_data", data_out, 64'd89);
        repeat (2) @(posedge clk);
        #1;
        check("s1o10_hold", {63'd0, done}, 64'd1);
        drop_load();
        check("s1o10_fall", {63'd0, done}, 64'd0);
        check("s1o10_keep", data_out, 64'd89);

        run_req(64'd3, 16'd5, lat);
        check("s3o5_lat", 64'(lat), 64'd5);
        check_flags("s3o5", 1'b1, 1'b0, 1'b0);
        check("s3o5_data", data_out, 64'd24);
        drop_load();

        run_req(64'd7, 16'd1, lat);
        check("o1_lat", 64'(lat), 64'd1);
        check("o1_data", data_out, 64'd7);
        drop_load();

        run_req(64'd0, 16'd6, lat);
        check("seed0_data", data_out, 64'd0);
        check("seed0_done", {63'd0, done}, 64'd1);
        drop_load();

        // Largest term that fits, then the first one that carries out
        run_req(64'd1, 16'd92, lat);
        check("o92_lat", 64'(lat), 64'd92);
        check_flags("o92", 1'b1, 1'b0, 1'b0);
        check("o92_data", data_out, 64'd12200160415121876738);
        drop_load();

        run_req(64'd1, 16'd93, lat);
        check("o93_lat", 64'(lat), 64'd92);
        check_flags("o93", 1'b0, 1'b0, 1'b1);
`ifdef FIB_SATURATE_EN
        check("o93_data", data_out, 64'd18446744073709551615);
`else
        check("o93_data", data_out, 64'd1293530146158671551);
`endif
        drop_load();
        repeat (3) @(posedge clk);
        #1;
        check_flags("o93_sticky", 1'b0, 1'b0, 1'b1);
        pulse_clear();

        // Order 0 error path
        run_req(64'd55, 16'd0, lat);
        check("o0_lat", 64'(lat), 64'd0);
        check_flags("o0", 1'b0, 1'b1, 1'b0);
        check("o0_data", data_out, 64'd0);
        drop_load();
        repeat (3) @(posedge clk);
        #1;
        check_flags("o0_sticky", 1'b0, 1'b1, 1'b0);
        pulse_clear();
        run_req(64'd2, 16'd3, lat);
        check("s2o3_lat", 64'(lat), 64'd3);
        check("s2o3_data", data_out, 64'd6);
        drop_load();

        // Reset in the middle of a long computation
        @(negedge clk);
        load = 1'b1;
        data_in = 64'd200;
        order = 16'd250;
        repeat (2) @(posedge clk);
        repeat ($urandom_range(5, 40)) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        check_flags("midreset", 1'b0, 1'b0, 1'b0);
        check("midreset_data", data_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_req(64'd1, 16'd10, lat);
        check("postreset_lat", 64'(lat), 64'd10);
        check("postreset_data", data_out, 64'd89);
        drop_load();

        // clear aborts a computation without raising any flag
        @(negedge clk);
        load = 1'b1;
        data_in = 64'd1;
        order = 16'd50;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        load = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        check("abort_data", data_out, 64'd89);

        // load with clear in IDLE: nothing captured until clear drops
        @(negedge clk);
        clear = 1'b1;
        load = 1'b1;
        data_in = 64'd5;
        order = 16'd1;
        repeat (5) @(posedge clk);
        #1;
        check_flags("blocked", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        data_in = 64'd7;
        order = 16'd2;
        @(posedge clk);
        @(posedge clk);
        #1;
        lat = 0;
        while (!(done || error || overflow) && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("unblock_lat", 64'(lat), 64'd2);
        check("unblock_data", data_out, 64'd14);
        drop_load();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
